seq_responder: RTL and testbench
================================

# seq_responder

Receiving end of the RA/RB/TM control strobes produced by the START/JP sequencer. It decodes the strobe stream back into sequencer states, checks that the stream is a legal sequence, and runs the associated datapath:
- captures operand A, then optionally operand B;
- produces the transfer result on TM.

It sits in the same clock domain as the sequencer, with RA/RB/TM wired straight across.

## Interface
- WIDTH, 8, operand width of DIN and of the internal A/B registers
- CLK  input  1  rising-edge clock
- RESET  input  1  reset; one clock, reset is synchronous and active-high
- RA  input  1  sequencer strobe: load A
- RB  input  1  sequencer strobe: load B
- TM  input  1  sequencer strobe: transfer/terminate
- DIN  input  WIDTH  operand data, sampled on load cycles
- RESULT  output  WIDTH+1  last transfer result, registered
- DONE  output  1  one-cycle pulse: a legal sequence completed
- JUMPED  output  1  path flag for the last completed sequence (1 = short path, B skipped)
- ERR  output  1  sticky protocol-violation flag
- COUNT  output  8  completed-sequence counter, wraps
- ERR_CNT  output  8  violation counter (see Configuration)

## Operation
- Control code is {RA,RB,TM}, sampled every rising CLK edge.
- Legal codes: 000 (idle), 100 (S1), 110 (S2), 001 (S3). Codes 010, 011, 101 and 111 are illegal in every state.
- Decoder FSM states and transitions:
  - IDLE:
    - 000 -> IDLE.
    - 100 -> GOT_A; REG_A <= DIN.
    - Any other code -> violation.
  - GOT_A:
    - 110 -> GOT_B; REG_B <= DIN.
    - 001 -> GOT_T; RESULT <= {1'b0,REG_A}; JUMPED <= 1; DONE pulse; COUNT+1.
    - Any other code, including a repeated 100, -> violation.
  - GOT_B:
    - 001 -> GOT_T; RESULT <= REG_A + REG_B at full WIDTH+1 (carry kept); JUMPED <= 0; DONE pulse; COUNT+1.
    - Any other code, including a repeated 110, -> violation.
  - GOT_T:
    - 000 -> IDLE.
    - Any other code -> violation. A back-to-back 100 with no idle cycle between sequences is a violation.
  - HUNT:
    - 000 -> IDLE.
    - Any other code -> HUNT, with no new violation recorded.
- Violation handling:
  - ERR <= 1; it stays set until RESET.
  - Next state is HUNT.
  - RESULT, JUMPED, COUNT, REG_A and REG_B hold their values.
  - No DONE pulse.
- COUNT wraps from 255 to 0.
- RESET takes priority over every other condition. An in-flight sequence is abandoned with no DONE.

## Timing
- Outputs are registered and change only on the rising CLK edge.
- Latency: at the edge where 001 is sampled, RESULT, JUMPED and COUNT update and DONE goes high for exactly one cycle.
- ERR rises at the edge where the violating code is sampled.
- Minimum legal sequence spacing: one 000 cycle after 001. A new sequence can therefore start every 3 cycles (short path) or every 4 cycles (long path).
- REG_A and REG_B load at the edge where 100 or 110 is sampled, respectively. DIN needs to be valid only on those cycles.
- State after RESET edge: IDLE. Outputs after RESET edge: RESULT=0, DONE=0, JUMPED=0, ERR=0, COUNT=0, ERR_CNT=0. REG_A=REG_B=0.
- RESET asserted on a 001 cycle: reset wins; no DONE and no COUNT increment.

## Configuration
- SEQ_RESPONDER_ERRCNT_EN:
  - When defined: ERR_CNT is an 8-bit saturating counter (stops at 255). It increments once per violation entry from IDLE, GOT_A, GOT_B or GOT_T, but not while in HUNT. It is cleared only by RESET.
  - When undefined: ERR_CNT is tied to 0. ERR behaviour is unchanged.

## Test plan
- Long path: RESET, then codes 000,100(DIN=0xF0),110(DIN=0x20),001,000 -> DONE one cycle after 001 sampled, RESULT=0x110, JUMPED=0, COUNT=1, ERR=0.
- Short path: 100(DIN=0x7F),001,000 -> RESULT=0x07F, JUMPED=1, COUNT increments by 1, single-cycle DONE.
- Violations:
  - 100,100 -> ERR=1, no DONE, state HUNT.
  - Then 110,001 -> still no DONE and ERR_CNT unchanged.
  - Then 000,100(DIN=1),001 -> DONE, RESULT=0x001, ERR still 1.
  - ERR_CNT=1 with macro defined, 0 without it.
- Illegal code 111 in IDLE, and 100 directly after 001 (no idle cycle) -> each sets ERR and enters HUNT. ERR_CNT=2 with macro defined. RESULT unchanged.
- Wrap and reset:
  - 256 back-to-back short-path sequences -> COUNT returns to 0.
  - RESET asserted on the 001 cycle of a long path -> no DONE; all outputs 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/seq_responder.sv
// seq_responder: receiving end of the RA/RB/TM sequencer strobes.
// Decodes {RA,RB,TM} back into sequencer states and checks that the stream is legal.
// Captures operand A, and operand B on the long path.
// Produces the transfer result when TM arrives.
// Optional feature macro: SEQ_RESPONDER_ERRCNT_EN enables the saturating ERR_CNT counter;
// when it is undefined, ERR_CNT is tied to zero.
module seq_responder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RA,
  input  logic             RB,
  input  logic             TM,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH:0]   RESULT,
  output logic             DONE,
  output logic             JUMPED,
  output logic             ERR,
  output logic [7:0]       COUNT,
  output logic [7:0]       ERR_CNT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOT_A = 3'd1,
    GOT_B = 3'd2,
    GOT_T = 3'd3,
    HUNT  = 3'd4
  } state_t;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_S1   = 3'b100;
  localparam logic [2:0] C_S2   = 3'b110;
  localparam logic [2:0] C_S3   = 3'b001;

  state_t           state;
  logic [2:0]       code;
  logic             viol;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;

  // Full-width sum; the carry becomes the top bit of RESULT.
  function automatic logic [WIDTH:0] add_full(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign code = {RA, RB, TM};

  // Flag a protocol violation for the current state/code pair; HUNT never reports a new one.
  always_comb begin
    viol = 1'b0;
    case (state)
      IDLE:    viol = !((code == C_IDLE) || (code == C_S1));
      GOT_A:   viol = !((code == C_S2) || (code == C_S3));
      GOT_B:   viol = (code != C_S3);
      GOT_T:   viol = (code != C_IDLE);
      default: viol = 1'b0;
    endcase
  end

  // Decoder FSM with the operand registers and all registered outputs.
  always_ff @(posedge CLK) begin
    DONE <= 1'b0;
    if (RESET) begin
      state  <= IDLE;
      reg_a  <= '0;
      reg_b  <= '0;
      RESULT <= '0;
      JUMPED <= 1'b0;
      ERR    <= 1'b0;
      COUNT  <= 8'd0;
`ifdef SEQ_RESPONDER_ERRCNT_EN
      ERR_CNT <= 8'd0;
`endif
    end else if (viol) begin
      // Datapath and counters hold; only the error status moves.
      state <= HUNT;
      ERR   <= 1'b1;
`ifdef SEQ_RESPONDER_ERRCNT_EN
      ERR_CNT <= sat_inc8(ERR_CNT);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (code == C_S1) begin
            reg_a <= DIN;
            state <= GOT_A;
          end
        end
        GOT_A: begin
          if (code == C_S2) begin
            reg_b <= DIN;
            state <= GOT_B;
          end else begin
            // Short path: B was skipped, pass A through.
            RESULT <= {1'b0, reg_a};
            JUMPED <= 1'b1;
            DONE   <= 1'b1;
            COUNT  <= COUNT + 8'd1;
            state  <= GOT_T;
          end
        end
        GOT_B: begin
          RESULT <= add_full(reg_a, reg_b);
          JUMPED <= 1'b0;
          DONE   <= 1'b1;
          COUNT  <= COUNT + 8'd1;
          state  <= GOT_T;
        end
        GOT_T: state <= IDLE;
        HUNT: begin
          if (code == C_IDLE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_RESPONDER_ERRCNT_EN
  assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_seq_responder.sv
// Self-checking bench for seq_responder. Directed test-plan steps are followed by randomized sequences.
// Outputs are compared every cycle against a frame-based reference model.
module tb_seq_responder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RA = 1'b0, RB = 1'b0, TM = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic [8:0] RESULT;
  logic       DONE, JUMPED, ERR;
  logic [7:0] COUNT, ERR_CNT;

  int errors = 0;
  int checks = 0;

  // Reference model: the letters seen since the last idle boundary, plus a hunting flag.
  string      frame;
  bit         hunting;
  logic [7:0] m_a, m_b;
  logic [8:0] m_result;
  logic       m_done, m_jumped, m_err;
  logic [7:0] m_count, m_errcnt;

  seq_responder #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .RA(RA), .RB(RB), .TM(TM), .DIN(DIN),
    .RESULT(RESULT), .DONE(DONE), .JUMPED(JUMPED), .ERR(ERR),
    .COUNT(COUNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string letter(input logic [2:0] c);
    case (c)
      3'b000:  return "0";
      3'b100:  return "A";
      3'b110:  return "B";
      3'b001:  return "T";
      default: return "X";
    endcase
  endfunction

  task automatic model_reset();
    frame = ""; hunting = 0;
    m_a = 0; m_b = 0; m_result = 0; m_done = 0; m_jumped = 0;
    m_err = 0; m_count = 0; m_errcnt = 0;
  endtask

  task automatic model_violation();
    m_err = 1'b1;
    hunting = 1;
`ifdef SEQ_RESPONDER_ERRCNT_EN
    if (m_errcnt != 8'd255) m_errcnt = m_errcnt + 8'd1;
`endif
  endtask

  task automatic model_step(input logic [2:0] c, input logic [7:0] d, input logic rst);
    string l, cand;
    m_done = 0;
    if (rst) begin
      model_reset();
      return;
    end
    l = letter(c);
    if (hunting) begin
      if (l == "0") begin hunting = 0; frame = ""; end
      return;
    end
    if (l == "0") begin
      // An idle code is only legal between complete sequences.
      if (frame == "" || frame == "AT" || frame == "ABT") frame = "";
      else model_violation();
      return;
    end
    cand = {frame, l};
    if (cand == "A" || cand == "AB" || cand == "AT" || cand == "ABT") begin
      frame = cand;
      if (l == "A") m_a = d;
      if (l == "B") m_b = d;
      if (l == "T") begin
        m_done = 1;
        m_jumped = (cand == "AT");
        m_result = (cand == "AT") ? {1'b0, m_a} : ({1'b0, m_a} + {1'b0, m_b});
        m_count = m_count + 8'd1;
      end
    end else begin
      model_violation();
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1 ns later.
  task automatic cyc(input logic [2:0] c, input logic [7:0] d, input logic rst = 1'b0);
    @(negedge CLK);
    {RA, RB, TM} = c; DIN = d; RESET = rst;
    @(posedge CLK);
    model_step(c, d, rst);
    #1;
    chk("result", RESULT, m_result);
    chk("done",   DONE,   m_done);
    chk("jumped", JUMPED, m_jumped);
    chk("err",    ERR,    m_err);
    chk("count",  COUNT,  m_count);
    chk("errcnt", ERR_CNT, m_errcnt);
  endtask

  function automatic logic [7:0] exp_errcnt(input logic [7:0] n);
`ifdef SEQ_RESPONDER_ERRCNT_EN
    return n;
`else
    return 8'd0 & n;
`endif
  endfunction

  initial begin
    model_reset();
    // Reset state
    cyc(3'b000, 8'h00, 1'b1);
    chk("reset_result", RESULT, 9'h000);
    chk("reset_count", COUNT, 8'd0);

    // Long path
    cyc(3'b000, 8'h00);
    cyc(3'b100, 8'hF0);
    cyc(3'b110, 8'h20);
    cyc(3'b001, 8'h00);
    chk("long_result", RESULT, 9'h110);
    chk("long_jumped", JUMPED, 1'b0);
    chk("long_done", DONE, 1'b1);
    chk("long_count", COUNT, 8'd1);
    chk("long_err", ERR, 1'b0);
    cyc(3'b000, 8'h00);
    chk("long_done_drop", DONE, 1'b0);

    // Short path
    cyc(3'b100, 8'h7F);
    cyc(3'b001, 8'h00);
    chk("short_result", RESULT, 9'h07F);
    chk("short_jumped", JUMPED, 1'b1);
    chk("short_count", COUNT, 8'd2);
    cyc(3'b000, 8'h00);
    chk("short_done_drop", DONE, 1'b0);

    // Repeated S1 enters HUNT; later strobes are ignored until idle.
    cyc(3'b100, 8'h11);
    cyc(3'b100, 8'h22);
    chk("viol_err", ERR, 1'b1);
    chk("viol_nodone", DONE, 1'b0);
    cyc(3'b110, 8'h33);
    cyc(3'b001, 8'h00);
    chk("hunt_nodone", DONE, 1'b0);
    chk("hunt_errcnt", ERR_CNT, exp_errcnt(8'd1));
    cyc(3'b000, 8'h00);
    cyc(3'b100, 8'h01);
    cyc(3'b001, 8'h00);
    chk("recover_done", DONE, 1'b1);
    chk("recover_result", RESULT, 9'h001);
    chk("recover_err", ERR, 1'b1);
    cyc(3'b000, 8'h00);

    // Illegal code from IDLE, then S1 straight after S3
    cyc(3'b000, 8'h00, 1'b1);
    cyc(3'b111, 8'h00);
    chk("ill111_err", ERR, 1'b1);
    cyc(3'b000, 8'h00);
    cyc(3'b100, 8'h05);
    cyc(3'b001, 8'h00);
    cyc(3'b100, 8'h66);
    chk("b2b_nodone", DONE, 1'b0);
    chk("b2b_result", RESULT, 9'h005);
    chk("b2b_errcnt", ERR_CNT, exp_errcnt(8'd2));
    cyc(3'b000, 8'h00);

    // 256 short-path sequences wrap COUNT back to zero
    cyc(3'b000, 8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      cyc(3'b100, 8'($urandom));
      cyc(3'b001, 8'h00);
      cyc(3'b000, 8'h00);
    end
    chk("wrap_count", COUNT, 8'd0);

    // Reset on the S3 cycle of a long path wins
    cyc(3'b100, 8'hAA);
    cyc(3'b110, 8'hBB);
    cyc(3'b001, 8'h00, 1'b1);
    chk("rst_s3_done", DONE, 1'b0);
    chk("rst_s3_result", RESULT, 9'h000);
    chk("rst_s3_count", COUNT, 8'd0);
    cyc(3'b100, 8'h3C);
    cyc(3'b001, 8'h00);
    chk("rst_idle_done", DONE, 1'b1);
    chk("rst_idle_result", RESULT, 9'h03C);
    cyc(3'b000, 8'h00);

    // Randomized mix of legal sequences, stray codes and resets
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel < 8) begin
        cyc(3'b100, 8'($urandom));
        cyc(3'b001, 8'($urandom));
        if ($urandom_range(0, 7) != 0) cyc(3'b000, 8'($urandom));
      end else if (sel < 16) begin
        cyc(3'b100, 8'($urandom));
        cyc(3'b110, 8'($urandom));
        cyc(3'b001, 8'($urandom));
        if ($urandom_range(0, 7) != 0) cyc(3'b000, 8'($urandom));
      end else if (sel < 19) begin
        cyc(3'($urandom), 8'($urandom));
      end else begin
        cyc(3'($urandom), 8'($urandom), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
